// File: rtl/arbitro_bordas_pkg.sv
// rtl/arbitro_bordas_pkg.sv - shared FSM encoding and default sizes for the edge-event arbiter
package arbitro_bordas_pkg;

    typedef enum logic {
        OCIOSO = 1'b0,
        OFERTA = 1'b1
    } estado_t;

    localparam int NUM_CANAIS_PADRAO = 2;
    localparam int CONT_W_PADRAO     = 3;

    // Round-robin successor of a channel index.
    function automatic int proximo_canal(input int atual, input int num_canais);
        return (atual + 1) % num_canais;
    endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// rtl/sincronizador_borda.sv - per-channel rising-edge detector, optional 2-flop sync (ARBITRO_SINCRONIZADOR_EN)
module sincronizador_borda (
    input  logic clk,
    input  logic rst,
    input  logic entrada,
    output logic borda
);

`ifdef ARBITRO_SINCRONIZADOR_EN
    logic meta;
    logic estavel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta    <= 1'b0;
            estavel <= 1'b0;
        end else begin
            meta    <= entrada;
            estavel <= meta;
        end
    end
`else
    logic estavel;

    assign estavel = entrada;
`endif

    // Cleared to 0 so a level already high at reset release counts as one event.
    logic anterior;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anterior <= 1'b0;
        end else begin
            anterior <= estavel;
        end
    end

    assign borda = estavel & ~anterior;

endmodule

// File: rtl/arbitro_bordas.sv
// rtl/arbitro_bordas.sv - round-robin arbiter of counted input edges (sync via ARBITRO_SINCRONIZADOR_EN)
module arbitro_bordas
    import arbitro_bordas_pkg::*;
#(
    parameter int NUM_CANAIS = NUM_CANAIS_PADRAO,
    parameter int CONT_W     = CONT_W_PADRAO
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CANAIS-1:0]         entrada,
    input  logic                          saida_pronta,
    input  logic                          limpa_ovf,
    output logic                          saida_valida,
    output logic [$clog2(NUM_CANAIS)-1:0] saida_canal,
    output logic [NUM_CANAIS-1:0]         pendentes,
    output logic [NUM_CANAIS-1:0]         overflow
);

    localparam int IDX_W = $clog2(NUM_CANAIS);
    localparam logic [CONT_W-1:0] CONT_MAX = '1;

    logic [NUM_CANAIS-1:0] borda;
    logic [CONT_W-1:0]     contador [NUM_CANAIS];
    logic [NUM_CANAIS-1:0] decrementa;
    logic [NUM_CANAIS-1:0] satura;
    logic [IDX_W-1:0]      ponteiro;
    logic [IDX_W-1:0]      escolha;
    logic                  escolha_ok;
    logic                  aceite;
    estado_t               estado;

    for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
        sincronizador_borda u_borda (
            .clk     (clk),
            .rst     (rst),
            .entrada (entrada[g]),
            .borda   (borda[g])
        );

        assign pendentes[g] = |contador[g];
    end

    // saida_valida is only ever high in OFERTA, so this is the handshake.
    assign aceite = saida_valida & saida_pronta;

    always_comb begin
        decrementa = '0;
        satura     = '0;
        for (int i = 0; i < NUM_CANAIS; i++) begin
            decrementa[i] = aceite && (saida_canal == IDX_W'(i));
            satura[i]     = borda[i] && !decrementa[i] && (contador[i] == CONT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CANAIS; i++) begin
                contador[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CANAIS; i++) begin
                if (borda[i] && !decrementa[i] && !satura[i]) begin
                    contador[i] <= contador[i] + 1'b1;
                end else if (decrementa[i] && !borda[i]) begin
                    contador[i] <= contador[i] - 1'b1;
                end
            end
            // A fresh saturation wins over a simultaneous clear.
            overflow <= (limpa_ovf ? '0 : overflow) | satura;
        end
    end

    // Scan from the highest offset down so the closest channel to ponteiro wins.
    always_comb begin
        int idx;
        idx        = 0;
        escolha_ok = 1'b0;
        escolha    = '0;
        for (int off = NUM_CANAIS - 1; off >= 0; off--) begin
            idx = (int'(ponteiro) + off) % NUM_CANAIS;
            if (pendentes[idx]) begin
                escolha_ok = 1'b1;
                escolha    = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado       <= OCIOSO;
            saida_valida <= 1'b0;
            saida_canal  <= '0;
            ponteiro     <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (escolha_ok) begin
                        saida_canal  <= escolha;
                        saida_valida <= 1'b1;
                        estado       <= OFERTA;
                    end
                end
                OFERTA: begin
                    if (saida_pronta) begin
                        ponteiro     <= IDX_W'(proximo_canal(int'(saida_canal), NUM_CANAIS));
                        saida_valida <= 1'b0;
                        estado       <= OCIOSO;
                    end
                end
                default: begin
                    estado       <= OCIOSO;
                    saida_valida <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_bordas.sv
// tb/tb_arbitro_bordas.sv - directed self-checking bench for arbitro_bordas
module tb_arbitro_bordas;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] entrada;
    logic       saida_pronta;
    logic       limpa_ovf;
    logic       saida_valida;
    logic [0:0] saida_canal;
    logic [1:0] pendentes;
    logic [1:0] overflow;

    int testes = 0;
    int falhas = 0;

`ifdef ARBITRO_SINCRONIZADOR_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    always #5 clk = ~clk;

    arbitro_bordas #(
        .NUM_CANAIS (2),
        .CONT_W     (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .entrada      (entrada),
        .saida_pronta (saida_pronta),
        .limpa_ovf    (limpa_ovf),
        .saida_valida (saida_valida),
        .saida_canal  (saida_canal),
        .pendentes    (pendentes),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testes++;
        if (obs !== exp) begin
            falhas++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic aplica_reset;
        rst          = 1'b0;
        entrada      = '0;
        saida_pronta = 1'b0;
        limpa_ovf    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic espera_valida(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (saida_valida) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int acc;
        int extra;

        // Reset state and single-event latency
        aplica_reset();
        chk("rst_valida", 32'(saida_valida), 0);
        chk("rst_canal", 32'(saida_canal), 0);
        chk("rst_pendentes", 32'(pendentes), 0);
        chk("rst_overflow", 32'(overflow), 0);
        saida_pronta = 1'b1;
        entrada = 2'b01;
        espera_valida(n);
        chk("s1_latencia", 32'(n), 32'(LAT));
        chk("s1_canal", 32'(saida_canal), 0);
        entrada = 2'b00;
        tick();
        chk("s1_valida_apos_aceite", 32'(saida_valida), 0);
        chk("s1_pendentes_apos", 32'(pendentes), 0);
        tick();
        chk("s1_sem_reoferta", 32'(saida_valida), 0);

        // Simultaneous rises, round-robin order
        aplica_reset();
        saida_pronta = 1'b1;
        entrada = 2'b11;
        espera_valida(n);
        chk("s2_latencia", 32'(n), 32'(LAT));
        chk("s2_canal0", 32'(saida_canal), 0);
        tick();
        chk("s2_valida_gap", 32'(saida_valida), 0);
        chk("s2_pendentes_mid", 32'(pendentes), 2);
        tick();
        chk("s2_valida_seg", 32'(saida_valida), 1);
        chk("s2_canal1", 32'(saida_canal), 1);
        tick();
        chk("s2_valida_fim", 32'(saida_valida), 0);
        chk("s2_pendentes_fim", 32'(pendentes), 0);
        chk("s2_ponteiro", 32'(dut.ponteiro), 0);
        entrada = 2'b00;

        // Saturation, overflow and its clear, then drain
        aplica_reset();
        repeat (9) begin
            entrada = 2'b10;
            tick();
            entrada = 2'b00;
            tick();
        end
        repeat (4) tick();
        chk("s3_overflow", 32'(overflow), 2);
        chk("s3_pendentes", 32'(pendentes), 2);
        chk("s3_valida", 32'(saida_valida), 1);
        chk("s3_canal", 32'(saida_canal), 1);
        limpa_ovf = 1'b1;
        tick();
        limpa_ovf = 1'b0;
        chk("s3_overflow_limpo", 32'(overflow), 0);
        chk("s3_pendentes_limpo", 32'(pendentes), 2);
        saida_pronta = 1'b1;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (!saida_valida && pendentes == 2'b00) break;
            if (saida_valida) acc++;
            tick();
        end
        chk("s3_aceites", 32'(acc), 7);
        chk("s3_pendentes_fim", 32'(pendentes), 0);
        chk("s3_overflow_fim", 32'(overflow), 0);
        saida_pronta = 1'b0;

        // Stalled offer stays stable while a new edge is counted
        aplica_reset();
        entrada = 2'b01;
        espera_valida(n);
        chk("s4_latencia", 32'(n), 32'(LAT));
        entrada = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) entrada = 2'b01;
            if (i == 2) entrada = 2'b00;
            tick();
            chk("s4_stall_valida", 32'(saida_valida), 1);
            chk("s4_stall_canal", 32'(saida_canal), 0);
        end
        saida_pronta = 1'b1;
        tick();
        chk("s4_valida_aceite", 32'(saida_valida), 0);
        chk("s4_pendentes_um", 32'(pendentes), 1);
        tick();
        chk("s4_reoferta", 32'(saida_valida), 1);
        chk("s4_reoferta_canal", 32'(saida_canal), 0);
        tick();
        chk("s4_valida_fim", 32'(saida_valida), 0);
        chk("s4_pendentes_fim", 32'(pendentes), 0);
        saida_pronta = 1'b0;

        // Reset during an offer, input held high across release
        aplica_reset();
        entrada = 2'b01;
        espera_valida(n);
        chk("s5_latencia", 32'(n), 32'(LAT));
        rst = 1'b0;
        #1;
        chk("s5_valida_rst", 32'(saida_valida), 0);
        chk("s5_pendentes_rst", 32'(pendentes), 0);
        tick();
        tick();
        rst = 1'b1;
        espera_valida(n);
        chk("s5_latencia_pos", 32'(n), 32'(LAT));
        chk("s5_canal", 32'(saida_canal), 0);
        saida_pronta = 1'b1;
        tick();
        chk("s5_valida_aceite", 32'(saida_valida), 0);
        extra = 0;
        repeat (8) begin
            tick();
            if (saida_valida) extra++;
        end
        chk("s5_ofertas_extra", 32'(extra), 0);
        chk("s5_pendentes_fim", 32'(pendentes), 0);
        entrada = 2'b00;

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/arbitro_bordas.md
ARBITRO_BORDAS -- requirements
Module: arbitro_bordas

Interface
REQ-001 Parameter NUM_CANAIS, default 2, number of input channels (2..8).
REQ-002 Parameter CONT_W, default 3, width of each per-channel pending-event counter.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 entrada  input  NUM_CANAIS  level inputs, one bit per channel; a rising edge is one event.
REQ-006 saida_pronta  input  1  consumer ready.
REQ-007 limpa_ovf  input  1  one-cycle pulse clearing all overflow flags.
REQ-008 saida_valida  output  1  event offered to consumer (registered).
REQ-009 saida_canal  output  clog2(NUM_CANAIS)  channel index of the offered event (registered).
REQ-010 pendentes  output  NUM_CANAIS  bit i high when counter i is nonzero.
REQ-011 overflow  output  NUM_CANAIS  sticky per-channel flag: event lost to saturation.

Function
REQ-012 Edge detection per channel: borda[i] = entrada[i] & ~entrada_ant[i]; entrada_ant updates to entrada every cycle.
REQ-013 Counter i increments on borda[i] and decrements on grant acceptance of channel i; both in the same cycle leave it unchanged.
REQ-014 Counter at 2^CONT_W-1 with borda[i] and no decrement: holds value, sets overflow[i].
REQ-015 limpa_ovf clears all overflow bits; simultaneous new overflow on channel i leaves overflow[i] set.
REQ-016 Two-state FSM: OCIOSO, OFERTA.
REQ-017 OCIOSO: if any counter nonzero, select first nonzero channel at or after ponteiro (wrapping modulo NUM_CANAIS), load saida_canal, assert saida_valida, go to OFERTA; else stay.
REQ-018 OFERTA: saida_valida and saida_canal hold stable until saida_valida & saida_pronta.
REQ-019 On acceptance: decrement counter[saida_canal], ponteiro <= (saida_canal+1) mod NUM_CANAIS, deassert saida_valida, go to OCIOSO.
REQ-020 Throughput: at most one accepted event per two cycles.
REQ-021 Latency: entrada[i] first sampled high at edge k (idle arbiter, empty counters) -> counter 1 after k -> saida_valida high after edge k+1.
REQ-022 Edges arriving during OFERTA are counted, never dropped unless saturated.

Reset
REQ-023 While rst low: counters, entrada_ant, overflow, ponteiro, saida_canal = 0; saida_valida = 0; FSM = OCIOSO.
REQ-024 Reset asserted mid-offer deasserts saida_valida immediately (asynchronously); pending events are discarded.
REQ-025 entrada_ant resets to 0, so an input already high at reset release produces one event.

Configuration
REQ-026 Macro ARBITRO_SINCRONIZADOR_EN: when defined, each entrada bit passes a two-flop synchronizer (reset to 0) before edge detection, adding 2 cycles to REQ-021 latency; when undefined, entrada feeds edge detection directly.

Structure
REQ-027 Shared package arbitro_bordas_pkg holds FSM state encoding (OCIOSO=0, OFERTA=1) and default NUM_CANAIS/CONT_W constants.
REQ-028 One sub-module, sincronizador_borda (per-channel optional synchronizer plus edge detector), instantiated NUM_CANAIS times; counters, FSM, round-robin in top level.

Verification
REQ-029 Single rise on entrada[0], saida_pronta=1 -> saida_valida high exactly two edges after rise sampled, saida_canal=0, one acceptance, pendentes=0 afterward.
REQ-030 Both channels rise same cycle, saida_pronta=1 -> grants channel 0 then channel 1, four cycles total; ponteiro ends at 0.
REQ-031 saida_pronta=0, 9 rises on channel 1 (CONT_W=3) -> counter stops at 7, overflow[1]=1; limpa_ovf pulse -> overflow[1]=0, counter still 7; then 7 acceptances drain it.
REQ-032 Offer pending on channel 0, saida_pronta low 5 cycles -> saida_valida/saida_canal stable; new rise on channel 0 during stall -> counter 2 before acceptance, 1 after.
REQ-033 rst low during OFERTA -> saida_valida 0 same cycle, all counters 0; entrada held high across release -> exactly one event offered.
REQ-034 Build with ARBITRO_SINCRONIZADOR_EN -> REQ-029 latency becomes four edges; all other scenarios pass unchanged.
